icache_sa: RTL and testbench
============================

Name: icache_sa

Overview:
- Parametrised set-associative instruction cache with a line-fill state machine and a flush capability.
- Sits between the fetch stage and main memory.
- Hits return data combinationally in the lookup cycle; misses perform one whole-line fill over a req/ready handshake.
- Adds configurable ways, sets and line size, round-robin replacement, flush, and hit/miss counters.

Parameters:
- ADDR_W, 20 (PHY_LEN): physical address width.
- INST_W, 32 (INST_LEN): instruction width. Fixed 4-byte word.
- LINE_BYTES, 16: line size. Power of 2, minimum 4.
- SETS, 4: number of sets. Power of 2, minimum 2.
- WAYS, 2: associativity. Power of 2, minimum 1.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  fetch byte address. addr[1:0] ignored.
- enable  in  1  lookup request valid.
- flush  in  1  invalidate all lines.
- instr_data  out  INST_W  fetched word. Valid when enable=1 and miss=0.
- miss  out  1  1 = instr_data not valid this cycle.
- mem_req  out  1  line fill request.
- mem_addr  out  ADDR_W  line-aligned fill address; offset bits are 0.
- mem_ready  in  1  one-cycle pulse; mem_rdata is valid in that cycle.
- mem_rdata  in  LINE_BYTES*8  line data. Word k = bits [32k+31:32k].
- hit_count  out  32  lookups that hit.
- miss_count  out  32  fills started.

Behaviour:
- Address split:
  - OFF = log2(LINE_BYTES); word index = addr[OFF-1:2].
  - IDX = log2(SETS); set index = addr[OFF+IDX-1:OFF].
  - Tag = addr[ADDR_W-1:OFF+IDX].
- Storage: per way/set a valid bit, tag and line data; per set a round-robin victim pointer (log2 WAYS bits).
- Reset: all valid bits 0, pointers 0, counters 0, state IDLE, mem_req 0, mem_addr 0, instr_data 0.
  - miss = enable during reset; outputs are otherwise ignored while rst=1.
- Lookup (combinational):
  - hit = enable & state==IDLE & any valid way with matching tag.
  - miss = enable & ~hit.
  - instr_data = selected word of the hit way, else 0.
  - With enable=0: miss=0 and instr_data=0.
- FSM states: IDLE, FILL, INSTALL.
  - IDLE, enable & ~hit & ~flush: latch line address; go to FILL; miss_count++.
  - IDLE, flush=1: clear all valid bits at this edge; no fill starts; stay IDLE. flush takes priority over a miss.
  - FILL: mem_req=1 and mem_addr held stable until mem_ready.
    - On mem_ready: capture mem_rdata; go to INSTALL. mem_req is 0 from the next cycle.
  - INSTALL, no flush pending: write line, tag and valid=1 into the victim way. Advance that set's pointer modulo WAYS. Go to IDLE.
  - INSTALL, flush pending: discard the line; clear all valids; go to IDLE.
- Victim choice: lowest-index invalid way in the set; otherwise the pointer's way.
- Latency:
  - Hit: 0 cycles.
  - Miss: the first IDLE cycle after INSTALL hits, i.e. ready-to-hit takes 2 edges.
  - Minimum miss: 3 cycles plus memory wait.
- Pending flush:
  - flush asserted in FILL or INSTALL sets a pending flag, applied at INSTALL.
  - The flag is cleared there and by rst.
- While state != IDLE:
  - miss=1 whenever enable=1, regardless of addr.
  - A changed addr does not alter the outstanding fill.
- hit_count increments on every clock with state==IDLE & enable & hit, including repeated hits on the same address.
- Both counters wrap at 2^32.
- rst in any state, including mid-FILL, returns to the reset values at that edge.
  - mem_req is 0 in the next cycle.
  - A later mem_ready with state != FILL is ignored.
- mem_ready in IDLE or INSTALL is ignored.

Test Plan:
- Cold miss (defaults): rst then enable=1, addr=0x4_0010 → miss=1, miss_count=1; mem_req=1 and mem_addr=0x4_0010 next cycle. Memory pulses mem_ready 3 cycles later with words {0x13,0x93,0x113,0x193} → mem_req=0 next cycle; miss=0, instr_data=0x13 two edges after mem_ready.
- Same-line hit: addr=0x4_001C → miss=0, instr_data=0x193 same cycle; hit_count increments each cycle held.
- Conflict/replacement: fill 0x4_0050 (set 1, way 1), then 0x4_0090 (evicts way 0) → 0x4_0010 misses again; 0x4_0050 hits with its fill data.
- Flush: after the fills, pulse flush=1 for one cycle in IDLE → next cycle 0x4_0050 misses, mem_req=1, miss_count increments.
- Flush mid-fill: flush=1 during FILL, then mem_ready → the INSTALL line is discarded; next lookup of the same address misses again and starts a new fill.
- Reset mid-fill: rst=1 for one cycle during FILL → mem_req=0 next cycle, counters=0; a late mem_ready pulse is ignored; 0x4_0010 misses.

Source files
------------

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with a whole-line fill engine.
//
// Lookups are combinational. A hit returns the addressed word in the same
// cycle. A miss in IDLE latches the line address and runs one fill over a
// req/ready handshake. The captured line is then installed into the victim way.
// flush invalidates every line. If flush arrives while a fill is outstanding,
// it is remembered and applied when the install is reached, and the fetched
// line is dropped.
//
// Ports:
//   clk         core clock, rising edge
//   rst         synchronous, active-high reset
//   addr        fetch byte address (addr[1:0] ignored)
//   enable      lookup request valid
//   flush       invalidate all lines
//   instr_data  fetched word, valid when enable=1 and miss=0
//   miss        1 = instr_data not valid this cycle
//   mem_req     line fill request, held until mem_ready
//   mem_addr    line-aligned fill address
//   mem_ready   one-cycle pulse, mem_rdata valid in that cycle
//   mem_rdata   fill line, word k at bits [32k+31:32k]
//   hit_count   number of lookups that hit (wraps)
//   miss_count  number of fills started (wraps)
module icache_sa #(
  parameter int ADDR_W     = 20,
  parameter int INST_W     = 32,
  parameter int LINE_BYTES = 16,
  parameter int SETS       = 4,
  parameter int WAYS       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      enable,
  input  logic                      flush,
  output logic [INST_W-1:0]         instr_data,
  output logic                      miss,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ready,
  input  logic [LINE_BYTES*8-1:0]   mem_rdata,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_INSTALL = 2'd2
  } state_e;

  // Control and status flops
  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                pend_q, pend_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;

  // Cache storage
  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     valid_d [SETS];
  logic [PTR_W-1:0]    ptr_q [SETS];
  logic [PTR_W-1:0]    ptr_d [SETS];
  logic [TAG_W-1:0]    tag_q [SETS][WAYS];
  logic [LINE_W-1:0]   data_q [SETS][WAYS];

  // Lookup-side address fields
  logic [IDX-1:0]      set_s;
  logic [TAG_W-1:0]    tag_s;
  logic [OFF-1:0]      off_s;
  logic [WSEL_W-1:0]   word_s;
  logic [WAYS-1:0]     way_hit_s;
  logic [PTR_W-1:0]    hit_way_s;
  logic [LINE_W-1:0]   hit_line_s;
  logic [INST_W-1:0]   sel_word_s;
  logic                lookup_hit_s;

  // Fill-side fields, taken from the latched line address
  logic [IDX-1:0]      fill_set_s;
  logic [TAG_W-1:0]    fill_tag_s;
  logic [PTR_W-1:0]    victim_way_s;
  logic                install_we_s;

  assign set_s      = addr[OFF+IDX-1:OFF];
  assign tag_s      = addr[ADDR_W-1:OFF+IDX];
  assign off_s      = addr[OFF-1:0];
  assign word_s     = WSEL_W'(off_s >> 2);
  assign fill_set_s = mem_addr_q[OFF+IDX-1:OFF];
  assign fill_tag_s = mem_addr_q[ADDR_W-1:OFF+IDX];

  // Tag compare across the ways of the addressed set; lowest matching way wins
  always_comb begin
    way_hit_s = '0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit_s[w] = valid_q[set_s][w] && (tag_q[set_s][w] == tag_s);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit_s[w]) begin
        hit_way_s = PTR_W'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
  end

  // A hit is only reported in IDLE, so a fill in flight always reads as a miss
  assign lookup_hit_s = enable && !rst && (state_q == S_IDLE) && (|way_hit_s);
  assign hit_line_s   = data_q[set_s][hit_way_s];

  // Word select within the hit line
  always_comb begin
    sel_word_s = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (word_s == WSEL_W'(k)) begin
        sel_word_s = hit_line_s[k*INST_W +: INST_W];
      end else begin
        sel_word_s = sel_word_s;
      end
    end
  end

  assign instr_data = lookup_hit_s ? sel_word_s : '0;
  assign miss       = enable && !lookup_hit_s;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Victim choice: the lowest invalid way, else the set's round-robin pointer
  always_comb begin
    victim_way_s = ptr_q[fill_set_s];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_set_s][w]) begin
        victim_way_s = PTR_W'(w);
      end else begin
        victim_way_s = victim_way_s;
      end
    end
  end

  // Next-state logic for the fill engine, valid bits, pointers and counters
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    line_d       = line_q;
    pend_d       = pend_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    ptr_d        = ptr_q;
    install_we_s = 1'b0;
    hit_count_d  = lookup_hit_s ? (hit_count_q + 32'd1) : hit_count_q;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          // flush wins over a simultaneous miss; no fill is started
          for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
          end
        end else if (enable && !lookup_hit_s) begin
          mem_addr_d   = {addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          mem_req_d    = 1'b1;
          pend_d       = 1'b0;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        if (flush) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (mem_ready) begin
          line_d    = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_INSTALL;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      S_INSTALL: begin
        // A flush seen during the fill (or right now) drops the fetched line
        if (pend_q || flush) begin
          for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
          end
        end else begin
          install_we_s                      = 1'b1;
          valid_d[fill_set_s][victim_way_s] = 1'b1;
          ptr_d[fill_set_s] = (WAYS == 1) ? '0 : (ptr_q[fill_set_s] + PTR_W'(1));
        end
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        pend_d    = 1'b0;
      end
    endcase
  end

  // State, control and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      line_q       <= '0;
      pend_q       <= 1'b0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      line_q       <= line_d;
      pend_q       <= pend_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= valid_d[s];
        ptr_q[s]   <= ptr_d[s];
      end
    end
  end

  // Tag and line storage; contents are only meaningful where valid is set
  always_ff @(posedge clk) begin
    if (install_we_s && !rst) begin
      tag_q[fill_set_s][victim_way_s]  <= fill_tag_s;
      data_q[fill_set_s][victim_way_s] <= line_q;
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa. A transaction-level cache model (sets of
// ways with round-robin victims) predicts hit/miss, data, fill addresses and
// counter values for directed and randomized fetch sequences.
module tb_icache_sa;

  localparam int ADDR_W     = 20;
  localparam int INST_W     = 32;
  localparam int LINE_BYTES = 16;
  localparam int SETS       = 4;
  localparam int WAYS       = 2;
  localparam int WORDS      = LINE_BYTES / 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [ADDR_W-1:0]       addr;
  logic                    enable;
  logic                    flush;
  logic [INST_W-1:0]       instr_data;
  logic                    miss;
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_ready;
  logic [LINE_BYTES*8-1:0] mem_rdata;
  logic [31:0]             hit_count;
  logic [31:0]             miss_count;

  icache_sa #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .enable(enable), .flush(flush),
    .instr_data(instr_data), .miss(miss), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [127:0] m_line [SETS][WAYS];
  int          m_ptr   [SETS];
  logic [31:0] exp_hits;
  logic [31:0] exp_misses;

  function automatic int set_of(input logic [ADDR_W-1:0] a);
    return int'((32'(a) / LINE_BYTES) % SETS);
  endfunction

  function automatic int unsigned tag_of(input logic [ADDR_W-1:0] a);
    return 32'(a) / (LINE_BYTES * SETS);
  endfunction

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return ADDR_W'((32'(a) / LINE_BYTES) * LINE_BYTES);
  endfunction

  // Memory image: word k of a line; line 0x4_0010 reads 0x13,0x93,0x113,0x193
  function automatic logic [127:0] line_data(input logic [ADDR_W-1:0] la);
    logic [127:0] r;
    logic [31:0]  base;
    base = (32'(la) ^ 32'h0004_0010) << 8;
    r = '0;
    for (int k = 0; k < WORDS; k++) begin
      r[k*32 +: 32] = 32'h13 + 32'h80 * 32'(k) + base;
    end
    return r;
  endfunction

  function automatic int model_find(input logic [ADDR_W-1:0] a);
    int s;
    s = set_of(a);
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == tag_of(a)) return w;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a, input int w);
    logic [127:0] l;
    l = m_line[set_of(a)][w];
    return l[((32'(a) % LINE_BYTES) / 4) * 32 +: 32];
  endfunction

  task automatic model_flush();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
  endtask

  task automatic model_install(input logic [ADDR_W-1:0] a);
    int s;
    int v;
    s = set_of(a);
    v = -1;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) v = m_ptr[s];
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = tag_of(a);
    m_line[s][v]  = line_data(line_of(a));
    m_ptr[s]      = (m_ptr[s] + 1) % WAYS;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch of address a. On a miss the memory answers after wait_cyc idle
  // FILL cycles; flush_at (>=0) pulses flush in that FILL cycle. Leaves enable=0.
  task automatic do_access(input logic [ADDR_W-1:0] a, input int wait_cyc, input int flush_at);
    int w;
    logic [ADDR_W-1:0] la;
    la = line_of(a);
    enable = 1'b1; addr = a; flush = 1'b0;
    #1;
    w = model_find(a);
    if (w >= 0) begin
      n_total++;
      if (miss !== 1'b0) $display("FAIL acc_hit_miss a=%h got %b exp 0", a, miss); else n_pass++;
      n_total++;
      if (instr_data !== model_word(a, w)) $display("FAIL acc_hit_data a=%h got %h exp %h", a, instr_data, model_word(a, w)); else n_pass++;
      step(); exp_hits++;
      n_total++;
      if (hit_count !== exp_hits) $display("FAIL acc_hit_count got %0d exp %0d", hit_count, exp_hits); else n_pass++;
    end else begin
      n_total++;
      if (miss !== 1'b1) $display("FAIL acc_miss a=%h got %b exp 1", a, miss); else n_pass++;
      n_total++;
      if (instr_data !== 32'h0) $display("FAIL acc_miss_data got %h exp 0", instr_data); else n_pass++;
      step(); exp_misses++;
      n_total++;
      if (miss_count !== exp_misses) $display("FAIL acc_miss_count got %0d exp %0d", miss_count, exp_misses); else n_pass++;
      for (int i = 0; i <= wait_cyc; i++) begin
        flush  = (i == flush_at);
        addr   = ADDR_W'($urandom);
        enable = 1'b1;
        if (i == wait_cyc) begin
          mem_ready = 1'b1;
          mem_rdata = line_data(la);
        end
        #1;
        n_total++;
        if (mem_req !== 1'b1 || mem_addr !== la) $display("FAIL fill_req got req=%b addr=%h exp req=1 addr=%h", mem_req, mem_addr, la); else n_pass++;
        n_total++;
        if (miss !== 1'b1) $display("FAIL fill_busy_miss got %b exp 1", miss); else n_pass++;
        step();
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      flush = 1'b0;
      n_total++;
      if (mem_req !== 1'b0) $display("FAIL req_drop got %b exp 0", mem_req); else n_pass++;
      n_total++;
      if (miss !== 1'b1) $display("FAIL install_miss got %b exp 1", miss); else n_pass++;
      step();
      if (flush_at >= 0 && flush_at <= wait_cyc) model_flush(); else model_install(a);
      addr = a;
      #1;
      w = model_find(a);
      if (w >= 0) begin
        n_total++;
        if (miss !== 1'b0 || instr_data !== model_word(a, w))
          $display("FAIL post_fill_hit a=%h got miss=%b data=%h exp miss=0 data=%h", a, miss, instr_data, model_word(a, w));
        else n_pass++;
        step(); exp_hits++;
        n_total++;
        if (hit_count !== exp_hits) $display("FAIL post_fill_hit_count got %0d exp %0d", hit_count, exp_hits); else n_pass++;
      end else begin
        n_total++;
        if (miss !== 1'b1) $display("FAIL discard_miss a=%h got %b exp 1", a, miss); else n_pass++;
      end
    end
    enable = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    addr = 20'h4_0010; mem_rdata = '0;
    step();
    n_total++;
    if (miss !== 1'b1) $display("FAIL reset_miss got %b exp 1", miss); else n_pass++;
    step();
    rst = 1'b0; enable = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (miss !== 1'b0 || instr_data !== 32'h0) $display("FAIL reset_idle_out got miss=%b data=%h exp 0/0", miss, instr_data); else n_pass++;
    n_total++;
    if (mem_req !== 1'b0 || mem_addr !== 20'h0) $display("FAIL reset_mem got req=%b addr=%h exp 0/0", mem_req, mem_addr); else n_pass++;
    n_total++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) $display("FAIL reset_counts got %0d/%0d exp 0/0", hit_count, miss_count); else n_pass++;
  endtask

  task automatic test_cold_miss();
    do_access(20'h4_0010, 3, -1);
    enable = 1'b1; addr = 20'h4_0010;
    #1;
    n_total++;
    if (instr_data !== 32'h13) $display("FAIL cold_word0 got %h exp 00000013", instr_data); else n_pass++;
    enable = 1'b0;
    #1;
  endtask

  task automatic test_same_line_hit();
    enable = 1'b1; addr = 20'h4_001C;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (miss !== 1'b0 || instr_data !== 32'h193) $display("FAIL same_line got miss=%b data=%h exp 0/00000193", miss, instr_data); else n_pass++;
      step(); exp_hits++;
      n_total++;
      if (hit_count !== exp_hits) $display("FAIL same_line_count got %0d exp %0d", hit_count, exp_hits); else n_pass++;
    end
    enable = 1'b0;
    #1;
  endtask

  task automatic test_replacement();
    do_access(20'h4_0050, 1, -1);
    do_access(20'h4_0090, 0, -1);
    enable = 1'b1; addr = 20'h4_0054;
    #1;
    n_total++;
    if (miss !== 1'b0 || instr_data !== 32'h0000_4093) $display("FAIL repl_keep got miss=%b data=%h exp 0/00004093", miss, instr_data); else n_pass++;
    addr = 20'h4_0010;
    #1;
    n_total++;
    if (miss !== 1'b1) $display("FAIL repl_evicted got %b exp 1", miss); else n_pass++;
    enable = 1'b0;
    #1;
    do_access(20'h4_0010, 2, -1);
    do_access(20'h4_0050, 0, -1);
  endtask

  task automatic test_flush();
    // flush beats a simultaneous miss
    enable = 1'b1; addr = 20'h4_0110; flush = 1'b1;
    #1;
    step();
    model_flush();
    flush = 1'b0; enable = 1'b0;
    #1;
    n_total++;
    if (mem_req !== 1'b0 || miss_count !== exp_misses) $display("FAIL flush_prio got req=%b cnt=%0d exp 0/%0d", mem_req, miss_count, exp_misses); else n_pass++;
    do_access(20'h4_0050, 1, -1);
  endtask

  task automatic test_flush_mid_fill();
    do_access(20'h4_0090, 2, 1);
    do_access(20'h4_0090, 1, -1);
  endtask

  task automatic test_reset_mid_fill();
    enable = 1'b1; addr = 20'h4_0010;
    #1;
    n_total++;
    if (miss !== 1'b1) $display("FAIL rmf_start got %b exp 1", miss); else n_pass++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (mem_req !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL rmf_state got req=%b hits=%0d misses=%0d exp 0/0/0", mem_req, hit_count, miss_count);
    else n_pass++;
    mem_ready = 1'b1; mem_rdata = line_data(20'h4_0010);
    step();
    mem_ready = 1'b0;
    #1;
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL rmf_late_ready got %b exp 0", mem_req); else n_pass++;
    do_access(20'h4_0010, 0, -1);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    int wt;
    int fa;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          flush = 1'b1; enable = 1'b0;
          step();
          flush = 1'b0;
          model_flush();
        end
        1: begin
          // stray mem_ready while idle must be ignored
          mem_ready = 1'b1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
          step();
          mem_ready = 1'b0;
          n_total++;
          if (mem_req !== 1'b0) $display("FAIL rnd_stray_ready got %b exp 0", mem_req); else n_pass++;
        end
        default: begin
          a  = ADDR_W'(32'h4_0000 + 32'($urandom_range(0, 3)) * 64 + 32'($urandom_range(0, 3)) * 16 + 32'($urandom_range(0, 3)) * 4);
          wt = $urandom_range(0, 3);
          fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, wt)) : -1;
          do_access(a, wt, fa);
        end
      endcase
    end
    n_total++;
    if (miss_count !== exp_misses) $display("FAIL rnd_final_misses got %0d exp %0d", miss_count, exp_misses); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line_hit();
    test_replacement();
    test_flush();
    test_flush_mid_fill();
    test_reset_mid_fill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
